max_finder: RTL and testbench

MAX_FINDER -- requirements
Module: max_finder

---
 rtl/max_finder.sv | 136 +++++++++++++
 tb/tb_max_finder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/max_finder.sv
// Per-frame peak search over a stream of match scores; reports the best pixel once per frame.
// Optional search window around the held peak is enabled with `define MAX_WINDOW_EN.
module max_finder #(
  parameter int SCORE_W       = 16,
  parameter int SEARCH_RADIUS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tracking_mode,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic [9:0]         max_x,
  output logic [9:0]         max_y,
  output logic [SCORE_W-1:0] max_score,
  output logic               max_ready
);

  localparam logic [9:0] CENTER_X = 10'd320;
  localparam logic [9:0] CENTER_Y = 10'd240;

  typedef enum logic [1:0] {IDLE, ARMED, SCAN, REPORT} state_t;

  state_t             state;
  state_t             state_next;
  logic [9:0]         cand_x;
  logic [9:0]         cand_y;
  logic [SCORE_W-1:0] cand_score;
  logic               cand_found;
  logic [9:0]         cand_x_next;
  logic [9:0]         cand_y_next;
  logic [SCORE_W-1:0] cand_score_next;
  logic               cand_found_next;
  logic               eligible;
  logic               evaluate;
  logic               clear;

`ifdef MAX_WINDOW_EN
  localparam logic [10:0] RADIUS = 11'(SEARCH_RADIUS);

  // Absolute distance without wrap, so the window is naturally clamped at the frame edges.
  function automatic logic [10:0] dist(input logic [9:0] a, input logic [9:0] b);
    if (a >= b) dist = {1'b0, a} - {1'b0, b};
    else        dist = {1'b0, b} - {1'b0, a};
  endfunction

  assign eligible = (dist(x, max_x) <= RADIUS) && (dist(y, max_y) <= RADIUS);
`else
  assign eligible = 1'b1;
`endif

  always_comb begin
    state_next      = state;
    clear           = 1'b0;
    evaluate        = 1'b0;
    cand_x_next     = cand_x;
    cand_y_next     = cand_y;
    cand_score_next = cand_score;
    cand_found_next = cand_found;

    case (state)
      IDLE: begin
        if (tracking_mode) state_next = ARMED;
      end
      ARMED: begin
        if (!tracking_mode) begin
          state_next = IDLE;
        end else if (frame_start) begin
          state_next = SCAN;
          clear      = 1'b1;
          evaluate   = 1'b1;
        end
      end
      SCAN: begin
        if (!tracking_mode) begin
          state_next = IDLE;
        end else begin
          evaluate = 1'b1;
          clear    = frame_start;
        end
      end
      REPORT: state_next = ARMED;
      default: state_next = IDLE;
    endcase

    if (clear) begin
      cand_x_next     = '0;
      cand_y_next     = '0;
      cand_score_next = '0;
      cand_found_next = 1'b0;
    end

    // Strict greater-than keeps the earliest pixel in raster order on ties.
    if (evaluate && score_valid && eligible &&
        (!cand_found_next || (score > cand_score_next))) begin
      cand_x_next     = x;
      cand_y_next     = y;
      cand_score_next = score;
      cand_found_next = 1'b1;
    end

    // A restart in the same cycle as frame_end wins; the coincident score is already folded in.
    if ((state == SCAN) && tracking_mode && frame_end && !frame_start)
      state_next = cand_found_next ? REPORT : ARMED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand_x     <= '0;
      cand_y     <= '0;
      cand_score <= '0;
      cand_found <= 1'b0;
      max_x      <= CENTER_X;
      max_y      <= CENTER_Y;
      max_score  <= '0;
      max_ready  <= 1'b0;
    end else begin
      state      <= state_next;
      cand_x     <= cand_x_next;
      cand_y     <= cand_y_next;
      cand_score <= cand_score_next;
      cand_found <= cand_found_next;
      max_ready  <= (state_next == REPORT);
      if (state_next == REPORT) begin
        max_x     <= cand_x_next;
        max_y     <= cand_y_next;
        max_score <= cand_score_next;
      end
    end
  end

endmodule

// File: tb/tb_max_finder.sv
// Directed bench for max_finder: hand-computed peaks, ties, empty frames, mode drop and reset mid-frame.
module tb_max_finder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tracking_mode;
  logic        frame_start;
  logic        frame_end;
  logic        score_valid;
  logic [15:0] score;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [9:0]  max_x;
  logic [9:0]  max_y;
  logic [15:0] max_score;
  logic        max_ready;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int p           = 0;

  max_finder #(.SCORE_W(16), .SEARCH_RADIUS(64)) dut (
    .clk(clk), .rst_n(rst_n), .tracking_mode(tracking_mode),
    .frame_start(frame_start), .frame_end(frame_end),
    .score_valid(score_valid), .score(score), .x(x), .y(y),
    .max_x(max_x), .max_y(max_y), .max_score(max_score), .max_ready(max_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (max_ready === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] s, input logic [9:0] px,
                       input logic [9:0] py, input logic fs, input logic fe);
    score_valid = v;
    score       = s;
    x           = px;
    y           = py;
    frame_start = fs;
    frame_end   = fe;
    step();
    score_valid = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, 32'(max_x), 32'd320);
    check({tag, "_y"}, 32'(max_y), 32'd240);
    check({tag, "_score"}, 32'(max_score), 32'd0);
    check({tag, "_ready"}, 32'(max_ready), 32'd0);
  endtask

  // Called right after the frame_end cycle: pulse must be up now and gone one cycle later.
  task automatic expect_report(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                               input logic [15:0] es);
    check({tag, "_ready"}, 32'(max_ready), 32'd1);
    check({tag, "_x"}, 32'(max_x), 32'(ex));
    check({tag, "_y"}, 32'(max_y), 32'(ey));
    check({tag, "_score"}, 32'(max_score), 32'(es));
    step();
    check({tag, "_ready_drop"}, 32'(max_ready), 32'd0);
    check({tag, "_x_hold"}, 32'(max_x), 32'(ex));
  endtask

  initial begin
    rst_n = 1'b0; tracking_mode = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    score_valid = 1'b0; score = '0; x = '0; y = '0;

    // Basic peak and latency
    do_reset();
    check_reset_vals("rst");
    tracking_mode = 1'b1;
    step();
    p = pulses;
    drive(1, 16'h0050, 0, 0, 1, 0);
    drive(1, 16'h0100, 100, 50, 0, 0);
    drive(1, 16'h0020, 101, 50, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("t1_pre_end", 32'(max_ready), 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    expect_report("t1", 100, 50, 16'h0100);
    check("t1_pulses", 32'(pulses - p), 32'd1);

    // Ties keep the earliest pixel
    drive(1, 16'h0080, 10, 10, 1, 0);
    drive(1, 16'h0080, 20, 10, 0, 0);
    drive(1, 16'h0080, 5, 11, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    expect_report("t2", 10, 10, 16'h0080);

    // Empty frame, and frame_end while armed
    do_reset();
    step();
    p = pulses;
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    repeat (3) step();
    drive(0, 0, 0, 0, 0, 1);
    check("t3_ready", 32'(max_ready), 32'd0);
    step();
    check_reset_vals("t3_hold");
    check("t3_pulses", 32'(pulses - p), 32'd0);

    // tracking_mode drop mid-frame
    p = pulses;
    drive(1, 16'hFFFF, 7, 7, 1, 0);
    tracking_mode = 1'b0;
    drive(1, 16'h0010, 8, 8, 0, 0);
    tracking_mode = 1'b1;
    step();
    drive(0, 0, 0, 0, 0, 1);
    step();
    check("t4_no_pulse", 32'(pulses - p), 32'd0);
    drive(1, 16'h0100, 50, 60, 1, 0);
    drive(1, 16'h0200, 200, 100, 0, 0);
    drive(1, 16'h01FF, 201, 100, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    expect_report("t4", 200, 100, 16'h0200);
    check("t4_pulses", 32'(pulses - p), 32'd1);

    // Reset mid-scan discards the partial frame
    drive(1, 16'hFFFF, 1, 1, 1, 0);
    rst_n = 1'b0;
    step();
    check_reset_vals("t5_rst");
    rst_n = 1'b1;
    p = pulses;
    step();
    drive(0, 0, 0, 0, 0, 1);
    step();
    check("t5_no_pulse", 32'(pulses - p), 32'd0);
    drive(1, 16'h0008, 0, 0, 1, 0);
    drive(1, 16'h0010, 300, 200, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    expect_report("t5", 300, 200, 16'h0010);

    // Search window around the held peak
    do_reset();
    step();
    drive(1, 16'hF000, 500, 240, 1, 0);
    drive(1, 16'h0100, 330, 250, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
`ifdef MAX_WINDOW_EN
    expect_report("t6", 330, 250, 16'h0100);
`else
    expect_report("t6", 500, 240, 16'hF000);

    // Score coincident with frame_end is evaluated
    drive(1, 16'h0010, 1, 2, 1, 0);
    drive(1, 16'h0020, 3, 4, 0, 1);
    expect_report("t7", 3, 4, 16'h0020);

    // frame_start during scan restarts the frame
    drive(1, 16'h9000, 9, 9, 1, 0);
    drive(1, 16'h0001, 2, 2, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    expect_report("t8", 2, 2, 16'h0001);

    // Unsigned full-width compare
    drive(1, 16'h7FFF, 1, 1, 1, 0);
    drive(1, 16'h8000, 2, 2, 0, 0);
    drive(1, 16'h7FFE, 3, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    expect_report("t9", 2, 2, 16'h8000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
